// File: rtl/row_pe_layer_scheduler.sv
// Layer scheduler for a row-parallel LDPC decoder: sequences IB-RAM refresh, v2c/c2v loads,
// CNU/VNU latency waits and iteration control. All outputs are registered.
module row_pe_layer_scheduler #(
  parameter int unsigned VN_DEGREE       = 3,
  parameter int unsigned VN_PAGE_ADDR_BW = 6,
  parameter int unsigned REFRESH_PAGES   = 4,
  parameter int unsigned CNU_LATENCY     = 2,
  parameter int unsigned VNU_LATENCY     = 3,
  parameter int unsigned MAX_ITER        = 10
) (
  input  logic                       sys_clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       early_stop,
  output logic                       busy,
  output logic                       done,
  output logic [3:0]                 iter_cnt,
  output logic [1:0]                 layer_cnt,
  output logic                       v2c_src,
  output logic                       v2c_latch_en,
  output logic                       c2v_latch_en,
  output logic [1:0]                 load,
  output logic [1:0]                 parallel_en,
  output logic                       vnu_read_addr_offset,
  output logic [VN_PAGE_ADDR_BW:0]   vnu_page_addr,
  output logic [VN_DEGREE-1:0]       vnu_ib_ram_we,
  output logic                       hd_valid
);

  typedef enum logic [3:0] {
    StIdle, StRefresh, StV2cLoad, StCnuWait, StC2vLoad, StVnuWait, StLayerEnd, StIterEnd, StDone
  } state_e;

  localparam logic [VN_PAGE_ADDR_BW-1:0] LastPage  = VN_PAGE_ADDR_BW'(REFRESH_PAGES - 1);
  localparam logic [1:0]                 LastLayer = 2'(VN_DEGREE - 1);
  localparam logic [3:0]                 LastIter  = 4'(MAX_ITER - 1);
  localparam logic [3:0]                 CnuInit   = 4'(CNU_LATENCY - 1);
  localparam logic [3:0]                 VnuInit   = 4'(VNU_LATENCY - 1);

  state_e                     state_q, state_d;
  logic [3:0]                 iter_q, iter_d;
  logic [1:0]                 layer_q, layer_d;
  logic [VN_PAGE_ADDR_BW-1:0] page_q, page_d;
  logic [3:0]                 cnt_q, cnt_d;

  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       v2c_src_q, v2c_src_d;
  logic                       v2c_latch_q, v2c_latch_d;
  logic                       c2v_latch_q, c2v_latch_d;
  logic                       rd_off_q, rd_off_d;
  logic [VN_PAGE_ADDR_BW:0]   page_addr_q, page_addr_d;
  logic [VN_DEGREE-1:0]       we_q, we_d;
  logic                       hd_valid_q, hd_valid_d;

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    layer_d = layer_q;
    page_d  = page_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRefresh;
          iter_d  = '0;
          layer_d = '0;
          page_d  = '0;
        end
      end
      StRefresh: begin
        if (page_q == LastPage) begin
          state_d = StV2cLoad;
        end else begin
          page_d = page_q + 1'b1;
        end
      end
      StV2cLoad: begin
        state_d = StCnuWait;
        cnt_d   = CnuInit;
      end
      StCnuWait: begin
        if (cnt_q == '0) begin
          state_d = StC2vLoad;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StC2vLoad: begin
        state_d = StVnuWait;
        cnt_d   = VnuInit;
      end
      StVnuWait: begin
        if (cnt_q == '0) begin
          state_d = StLayerEnd;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StLayerEnd: begin
        if (layer_q == LastLayer) begin
          state_d = StIterEnd;
        end else begin
          state_d = StV2cLoad;
          layer_d = layer_q + 1'b1;
        end
      end
      StIterEnd: begin
        if (early_stop || (iter_q == LastIter)) begin
          state_d = StDone;
        end else begin
          state_d = StRefresh;
          iter_d  = iter_q + 1'b1;
          layer_d = '0;
          page_d  = '0;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are decoded from the next state so they are valid in the cycle the state is held.
    busy_d      = (state_d != StIdle) && (state_d != StDone);
    done_d      = (state_d == StDone);
    hd_valid_d  = (state_d == StIterEnd);
    v2c_latch_d = (state_d == StV2cLoad);
    c2v_latch_d = (state_d == StC2vLoad);
    rd_off_d    = (state_d != StIdle) ? iter_d[0] : 1'b0;
    v2c_src_d   = (state_d inside {StV2cLoad, StCnuWait, StC2vLoad, StVnuWait, StLayerEnd}) &&
                  (iter_d == '0) && (layer_d == '0);
    page_addr_d = '0;
    we_d        = '0;
    if (state_d == StRefresh) begin
      page_addr_d = {iter_d[0], page_d};
      we_d        = '1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= StIdle;
      iter_q      <= '0;
      layer_q     <= '0;
      page_q      <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      v2c_src_q   <= 1'b0;
      v2c_latch_q <= 1'b0;
      c2v_latch_q <= 1'b0;
      rd_off_q    <= 1'b0;
      page_addr_q <= '0;
      we_q        <= '0;
      hd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      iter_q      <= iter_d;
      layer_q     <= layer_d;
      page_q      <= page_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      v2c_src_q   <= v2c_src_d;
      v2c_latch_q <= v2c_latch_d;
      c2v_latch_q <= c2v_latch_d;
      rd_off_q    <= rd_off_d;
      page_addr_q <= page_addr_d;
      we_q        <= we_d;
      hd_valid_q  <= hd_valid_d;
    end
  end

  assign busy                 = busy_q;
  assign done                 = done_q;
  assign iter_cnt             = iter_q;
  assign layer_cnt            = layer_q;
  assign v2c_src              = v2c_src_q;
  assign v2c_latch_en         = v2c_latch_q;
  assign c2v_latch_en         = c2v_latch_q;
  assign load                 = {v2c_latch_q, c2v_latch_q};
  assign parallel_en          = {v2c_latch_q, c2v_latch_q};
  assign vnu_read_addr_offset = rd_off_q;
  assign vnu_page_addr        = page_addr_q;
  assign vnu_ib_ram_we        = we_q;
  assign hd_valid             = hd_valid_q;

endmodule

// File: tb/tb_row_pe_layer_scheduler.sv
// Directed bench for row_pe_layer_scheduler at default parameters.
// Cycle c is the period after edge c-1; inputs driven in cycle c are sampled at edge c.
module tb_row_pe_layer_scheduler;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       early_stop = 1'b0;
  logic       busy, done, v2c_src, v2c_latch_en, c2v_latch_en, vnu_read_addr_offset, hd_valid;
  logic [3:0] iter_cnt;
  logic [1:0] layer_cnt, load, parallel_en;
  logic [6:0] vnu_page_addr;
  logic [2:0] vnu_ib_ram_we;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int hd_count = 0;

  always #5 sys_clk = ~sys_clk;

  row_pe_layer_scheduler dut (
    .sys_clk              (sys_clk),
    .rst                  (rst),
    .start                (start),
    .early_stop           (early_stop),
    .busy                 (busy),
    .done                 (done),
    .iter_cnt             (iter_cnt),
    .layer_cnt            (layer_cnt),
    .v2c_src              (v2c_src),
    .v2c_latch_en         (v2c_latch_en),
    .c2v_latch_en         (c2v_latch_en),
    .load                 (load),
    .parallel_en          (parallel_en),
    .vnu_read_addr_offset (vnu_read_addr_offset),
    .vnu_page_addr        (vnu_page_addr),
    .vnu_ib_ram_we        (vnu_ib_ram_we),
    .hd_valid             (hd_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  task automatic chk_idle_zero(input string tag, input logic [3:0] it, input logic [1:0] ly);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_iter"}, 32'(iter_cnt), 32'(it));
    chk({tag, "_layer"}, 32'(layer_cnt), 32'(ly));
    chk({tag, "_ctl"}, {25'd0, v2c_src, v2c_latch_en, c2v_latch_en, load, parallel_en}, 0);
    chk({tag, "_off"}, 32'(vnu_read_addr_offset), 0);
    chk({tag, "_addr"}, 32'(vnu_page_addr), 0);
    chk({tag, "_we"}, 32'(vnu_ib_ram_we), 0);
    chk({tag, "_hd"}, 32'(hd_valid), 0);
  endtask

  // Expected outputs of a full 10-iteration decode started at edge 0.
  task automatic chk_full_run(input int c);
    int k, o;
    logic e_v2cl, e_c2vl;
    if (c >= 1 && c <= 290) begin
      k = (c - 1) / 29;
      o = (c - 1) % 29 + 1;
      e_v2cl = (o == 5) || (o == 13) || (o == 21);
      e_c2vl = (o == 8) || (o == 16) || (o == 24);
      chk("run_busy", 32'(busy), 1);
      chk("run_done", 32'(done), 0);
      chk("run_iter", 32'(iter_cnt), 32'(k));
      chk("run_layer", 32'(layer_cnt), (o <= 12) ? 0 : (o <= 20) ? 1 : 2);
      chk("run_hd", 32'(hd_valid), 32'(o == 29));
      chk("run_we", 32'(vnu_ib_ram_we), (o <= 4) ? 7 : 0);
      chk("run_addr", 32'(vnu_page_addr), (o <= 4) ? 32'((k % 2) * 64 + o - 1) : 0);
      chk("run_off", 32'(vnu_read_addr_offset), 32'(k % 2));
      chk("run_src", 32'(v2c_src), 32'(k == 0 && o >= 5 && o <= 12));
      chk("run_v2cl", 32'(v2c_latch_en), 32'(e_v2cl));
      chk("run_c2vl", 32'(c2v_latch_en), 32'(e_c2vl));
      chk("run_load", 32'(load), 32'({e_v2cl, e_c2vl}));
      chk("run_pen", 32'(parallel_en), 32'({e_v2cl, e_c2vl}));
    end else if (c == 291) begin
      chk("end_done", 32'(done), 1);
      chk("end_busy", 32'(busy), 0);
      chk("end_iter", 32'(iter_cnt), 9);
      chk("end_hd", 32'(hd_valid), 0);
      chk("end_off", 32'(vnu_read_addr_offset), 1);
    end else begin
      chk_idle_zero("post", 4'd9, 2'd2);
    end
  endtask

  initial begin
    // Reset state.
    tick();
    tick();
    rst = 1'b0;
    chk_idle_zero("reset", 4'd0, 2'd0);

    // Full decode with a stray start pulse in cycle 10.
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    hd_count = 0;
    while (cyc <= 292) begin
      chk_full_run(cyc);
      if (hd_valid === 1'b1) hd_count++;
      start = (cyc == 10);
      tick();
    end
    start = 1'b0;
    chk("run_hd_count", 32'(hd_count), 10);

    // Early stop held high: only the first ITER_END may act on it.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    early_stop = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    hd_count = 0;
    while (cyc <= 31) begin
      chk("es_hd", 32'(hd_valid), 32'(cyc == 29));
      chk("es_done", 32'(done), 32'(cyc == 30));
      chk("es_busy", 32'(busy), 32'(cyc <= 29));
      if (cyc == 30) chk("es_iter", 32'(iter_cnt), 0);
      if (hd_valid === 1'b1) hd_count++;
      tick();
    end
    early_stop = 1'b0;
    chk("es_hd_count", 32'(hd_count), 1);

    // Mid-decode reset with start held during the reset cycle.
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (cyc < 40) tick();
    chk("mid_iter", 32'(iter_cnt), 1);
    chk("mid_off", 32'(vnu_read_addr_offset), 1);
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    chk_idle_zero("rst41", 4'd0, 2'd0);
    while (cyc < 45) tick();
    chk("idle45_busy", 32'(busy), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("r46_busy", 32'(busy), 1);
    chk("r46_we", 32'(vnu_ib_ram_we), 7);
    chk("r46_addr", 32'(vnu_page_addr), 0);
    chk("r46_iter", 32'(iter_cnt), 0);
    while (cyc < 50) tick();
    chk("v50_src", 32'(v2c_src), 1);
    chk("v50_load", 32'(load), 2);

    // Start in the first cycle after reset deasserts.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("post_rst_busy", 32'(busy), 1);
    chk("post_rst_we", 32'(vnu_ib_ram_we), 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/row_pe_layer_scheduler.md
ROW_PE_LAYER_SCHEDULER -- requirements
Module: row_pe_layer_scheduler

Interface
REQ-001 SHALL have parameter VN_DEGREE, default 3, meaning layer count per iteration and IB-RAM write-enable width.
REQ-002 SHALL have parameter VN_PAGE_ADDR_BW, default 6, meaning IB-RAM page address width (excluding group MSB).
REQ-003 SHALL have parameter REFRESH_PAGES, default 4, range 1..2^VN_PAGE_ADDR_BW, meaning IB-RAM pages rewritten per iteration.
REQ-004 SHALL have parameter CNU_LATENCY, default 2, range 1..15, meaning CNU cycles from v2c latch to valid c2v.
REQ-005 SHALL have parameter VNU_LATENCY, default 3, range 1..15, meaning partial-VNU pipeline depth.
REQ-006 SHALL have parameter MAX_ITER, default 10, range 1..15, meaning decoding iteration limit.
REQ-007 SHALL have ports, in order: sys_clk in 1 clock; rst in 1 reset; start in 1 decode request; early_stop in 1 syndrome-satisfied flag; busy out 1; done out 1 completion pulse; iter_cnt out 4; layer_cnt out 2; v2c_src out 1 CNU input select (1=channel msg); v2c_latch_en out 1; c2v_latch_en out 1; load out 2 {v2c_load, c2v_load}; parallel_en out 2 {v2c_msg_en, c2v_msg_en}; vnu_read_addr_offset out 1 IB-RAM page-group read select; vnu_page_addr out VN_PAGE_ADDR_BW+1 refresh address, MSB = page group; vnu_ib_ram_we out VN_DEGREE; hd_valid out 1 hard-decision valid pulse.
REQ-008 SHALL use one clock, sys_clk; reset rst is synchronous and active-high.

Function
REQ-009 SHALL implement states IDLE, REFRESH, V2C_LOAD, CNU_WAIT, C2V_LOAD, VNU_WAIT, LAYER_END, ITER_END, DONE.
REQ-010 IDLE: start=1 sampled at an edge SHALL move to REFRESH, clear iter_cnt and layer_cnt; start outside IDLE SHALL be ignored.
REQ-011 REFRESH: SHALL last exactly REFRESH_PAGES cycles; cycle p drives vnu_page_addr={iter_cnt[0], p}, vnu_ib_ram_we all ones; then V2C_LOAD.
REQ-012 vnu_ib_ram_we SHALL be all zeros and vnu_page_addr zero in every state other than REFRESH.
REQ-013 vnu_read_addr_offset SHALL equal iter_cnt[0] in all non-IDLE states, 0 in IDLE.
REQ-014 V2C_LOAD: one cycle; v2c_latch_en=1, load=2'b10, parallel_en=2'b10; then CNU_WAIT.
REQ-015 v2c_src SHALL be 1 from V2C_LOAD through LAYER_END when iter_cnt=0 and layer_cnt=0, else 0.
REQ-016 CNU_WAIT: exactly CNU_LATENCY cycles via down-counter, then C2V_LOAD.
REQ-017 C2V_LOAD: one cycle; c2v_latch_en=1, load=2'b01, parallel_en=2'b01; then VNU_WAIT.
REQ-018 VNU_WAIT: exactly VNU_LATENCY cycles, then LAYER_END.
REQ-019 LAYER_END: one cycle; layer_cnt=VN_DEGREE-1 -> ITER_END (layer_cnt holds); else layer_cnt+1 -> V2C_LOAD.
REQ-020 ITER_END: one cycle, hd_valid=1; early_stop=1 or iter_cnt=MAX_ITER-1 -> DONE with counters held; else iter_cnt+1, layer_cnt=0 -> REFRESH.
REQ-021 early_stop SHALL be sampled only in ITER_END; other values ignored.
REQ-022 DONE: one cycle, done=1, busy=0; then IDLE; iter_cnt/layer_cnt hold final values until next start.
REQ-023 busy SHALL be 1 in all states except IDLE and DONE.
REQ-024 latch/load/parallel_en outputs SHALL be 0 in every state not listed for them.
REQ-025 Iteration length SHALL be REFRESH_PAGES + VN_DEGREE*(3+CNU_LATENCY+VNU_LATENCY) + 1 cycles (29 at defaults).
REQ-026 With start sampled at edge 0, ITER_END of iteration k SHALL occupy cycle 29(k+1) and DONE cycle 29N+1 (defaults, N iterations run).

Reset
REQ-027 rst=1 at an edge SHALL force IDLE and zero all outputs and counters next cycle, including mid-operation; rst overrides start.
REQ-028 start held high during the rst cycle SHALL NOT begin a decode; a start seen in the first cycle after rst deassertion SHALL.

Verification
REQ-029 Defaults, start pulse, early_stop=0 -> done=1 at cycle 291 only, iter_cnt=9, 10 hd_valid pulses at cycles 29,58,...,290.
REQ-030 early_stop=1 during first ITER_END -> done at cycle 30, iter_cnt=0, one hd_valid pulse.
REQ-031 Iteration 1 -> vnu_page_addr 64,65,66,67 with we=3'b111 in cycles 30-33; vnu_read_addr_offset=1 throughout iteration 1.
REQ-032 v2c_src=1 in cycles 5-12 only (iteration 0, layer 0); c2v_latch_en pulses at cycles 8,16,24 in iteration 0.
REQ-033 rst asserted at cycle 40 -> all outputs 0 at cycle 41; new start at 45 -> REFRESH from cycle 46, iter_cnt=0.
REQ-034 start re-pulsed at cycle 10 while busy -> no effect; done still at 291.
